// File: rtl/ua_mux_sequencer.sv
// Break-before-make scan sequencer for the analog pin transmission gates ua[NCH-1:0].
// Connects one enabled channel at a time, with dead time between channels and a strobe at the end of each dwell.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | all switches open, waiting for an effective start
//   BREAK | dead time: all switches open for DEAD_CYCLES cycles
//   DWELL | selected channel switch closed, down-counting the dwell time
module ua_mux_sequencer #(
    parameter int NCH         = 6,
    parameter int DWELL_W     = 8,
    parameter int DEAD_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               start,
    input  logic               stop,
    input  logic               single,
    input  logic [NCH-1:0]     ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [NCH-1:0]     sw_en,
    output logic               sample,
    output logic [2:0]         cur_ch,
    output logic               busy,
    output logic               pass_done
);

    localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DEAD_W-1:0] DEAD_INIT = DEAD_W'(DEAD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BREAK = 2'd1,
        DWELL = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [DEAD_W-1:0]  dead_cnt, dead_cnt_n;
    logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_n;
    logic [2:0]         cur_ch_n;
    logic [NCH-1:0]     sw_en_n;
    logic               sample_n;
    logic               pass_done_n;
    logic               busy_n;

    logic               halt;
    logic               mask_any;
    logic [2:0]         sel_ch;
    logic [2:0]         top_ch;
    logic [DWELL_W-1:0] dwell_load;

    // First set bit strictly after 'from', searching upward and wrapping; a lone
    // channel therefore reselects itself.
    function automatic logic [2:0] next_sel(input logic [2:0] from, input logic [NCH-1:0] mask);
        logic [2:0] r;
        logic       found;
        int         idx;
        r     = from;
        found = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
            idx = (int'(from) + i) % NCH;
            if (!found && mask[idx]) begin
                r     = 3'(idx);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [2:0] highest(input logic [NCH-1:0] mask);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < NCH; i++) begin
            if (mask[i]) begin
                r = 3'(i);
            end
        end
        return r;
    endfunction

    function automatic logic [NCH-1:0] onehot(input logic [2:0] ch);
        logic [NCH-1:0] one;
        one = NCH'(1);
        return one << ch;
    endfunction

    assign halt       = stop || !ena;
    assign mask_any   = |ch_mask;
    assign sel_ch     = next_sel(cur_ch, ch_mask);
    assign top_ch     = highest(ch_mask);
    assign dwell_load = (dwell == '0) ? '0 : dwell - 1'b1;

    always_comb begin
        state_n     = state;
        cur_ch_n    = cur_ch;
        dead_cnt_n  = dead_cnt;
        dwell_cnt_n = dwell_cnt;
        sw_en_n     = '0;
        sample_n    = 1'b0;
        pass_done_n = 1'b0;

        case (state)
            IDLE: begin
                if (start && !halt && mask_any) begin
                    state_n    = BREAK;
                    cur_ch_n   = sel_ch;
                    dead_cnt_n = DEAD_INIT;
                end
            end

            BREAK: begin
                if (halt) begin
                    state_n = IDLE;
                end else if (dead_cnt == '0) begin
                    state_n     = DWELL;
                    dwell_cnt_n = dwell_load;
                    sw_en_n     = onehot(cur_ch);
                end else begin
                    dead_cnt_n = dead_cnt - 1'b1;
                end
            end

            DWELL: begin
                if (halt) begin
                    state_n = IDLE;
                end else if (dwell_cnt == '0) begin
                    // pass_done is the registered flag of this final cycle
                    if (single && pass_done) begin
                        state_n = IDLE;
                    end else if (mask_any) begin
                        state_n    = BREAK;
                        cur_ch_n   = sel_ch;
                        dead_cnt_n = DEAD_INIT;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    dwell_cnt_n = dwell_cnt - 1'b1;
                    sw_en_n     = sw_en;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        // Strobes are registered, so they are raised on the edge entering the last dwell cycle.
        if (state_n == DWELL && dwell_cnt_n == '0) begin
            sample_n    = 1'b1;
            pass_done_n = mask_any && (cur_ch_n == top_ch);
        end
    end

    assign busy_n = (state_n != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dead_cnt  <= '0;
            dwell_cnt <= '0;
            cur_ch    <= 3'(NCH - 1);
            sw_en     <= '0;
            sample    <= 1'b0;
            pass_done <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            dead_cnt  <= dead_cnt_n;
            dwell_cnt <= dwell_cnt_n;
            cur_ch    <= cur_ch_n;
            sw_en     <= sw_en_n;
            sample    <= sample_n;
            pass_done <= pass_done_n;
            busy      <= busy_n;
        end
    end

endmodule

// File: doc/ua_mux_sequencer.md
Name: ua_mux_sequencer

Overview:
- Controls the transmission-gate switches that connect the on-chip analog node to the analog pins ua[5:0].
- Scans an enabled subset of pins one at a time, either round-robin or as a single pass.
- Enforces break-before-make dead time between channels and emits a sample strobe at the end of each dwell.
- Sits between the digital config inputs and the analog switch enables in the top-level wrapper.

Parameters:
- NCH, 6, number of analog channels (switch enables); max 8.
- DWELL_W, 8, width of the dwell-count input.
- DEAD_CYCLES, 2, all-switches-off cycles between channels; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  block enable; low acts as stop.
- start  in  1  pulse; begins a scan when idle.
- stop  in  1  abort request, sampled every cycle.
- single  in  1  1 = one pass through the mask then idle; 0 = continuous.
- ch_mask  in  NCH  channels eligible for scanning.
- dwell  in  DWELL_W  cycles a channel stays connected; 0 is treated as 1.
- sw_en  out  NCH  registered switch enables; at most one bit high.
- sample  out  1  one-cycle strobe on the last dwell cycle.
- cur_ch  out  3  index of the currently or most recently selected channel.
- busy  out  1  high whenever state != IDLE.
- pass_done  out  1  one-cycle pulse at the end of each pass.

Behaviour:
- Reset (async, rst_n low): state IDLE; sw_en=0, sample=0, busy=0, pass_done=0, cur_ch=NCH-1. The next search therefore starts at channel 0.
- States: IDLE, BREAK, DWELL.
- IDLE:
  - sw_en=0, busy=0.
  - Start is effective when start=1, ena=1, stop=0 and ch_mask!=0.
  - Effective start: perform selection; next state BREAK with dead counter = DEAD_CYCLES-1.
  - Start with ch_mask=0, or with stop or !ena: stay IDLE.
- Selection (on every BREAK entry):
  - cur_ch <= first set bit of ch_mask strictly after cur_ch, searching upward and wrapping modulo NCH.
  - ch_mask is sampled at that edge only; later mask changes affect only the next selection.
  - If the sampled mask is 0: go to IDLE instead of BREAK.
- BREAK:
  - sw_en=0 for exactly DEAD_CYCLES cycles.
  - Then DWELL, with sw_en = one-hot(cur_ch) on the same edge and the dwell counter loaded with max(dwell,1)-1.
- DWELL:
  - sw_en one-hot for exactly max(dwell,1) cycles; dwell is sampled on DWELL entry.
  - sample=1 on the final cycle only.
  - pass_done=1 coincident with sample when cur_ch is the highest set bit of the current ch_mask.
  - After the final cycle:
    - single=1 and pass_done: go IDLE; sw_en=0 next cycle.
    - Otherwise: selection, then BREAK.
- Single enabled channel: the block still passes through BREAK between dwells. Switches never stay continuously on.
- Stop (stop=1 or ena=0), sampled in any non-IDLE state: next cycle is IDLE with sw_en=0. No sample or pass_done is generated in that cycle; cur_ch holds.
- Stop has priority over the dwell-end transition in the same cycle. Start is ignored while busy.
- Break-before-make invariant: sw_en never changes directly from one nonzero value to a different nonzero value. At least DEAD_CYCLES all-zero cycles separate any two different nonzero values.
- Latency: effective start sampled at edge k gives busy=1 from k+1 and sw_en nonzero from edge k+DEAD_CYCLES+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. Reset mid-DWELL with sw_en=6'b000100 -> sw_en=0, busy=0, cur_ch=5 immediately, without waiting for a clock edge.
2. ch_mask=6'b101001, dwell=3, single=1, start pulse -> the sequence below, then IDLE, busy=0:
   - 2 zero cycles, sw_en=000001 for 3 cycles (sample on the 3rd);
   - 2 zero cycles, sw_en=001000 for 3 cycles;
   - 2 zero cycles, sw_en=100000 for 3 cycles, with sample and pass_done together on the last.
3. ch_mask=6'b000010, dwell=0, single=0 -> sw_en=000010 for 1 cycle with sample each time, alternating with 2 zero cycles, repeating. pass_done coincides with every sample.
4. Continuous scan with stop asserted on the 2nd DWELL cycle of ch3 -> next cycle IDLE, sw_en=0, no sample. A checker asserts the at-most-one-hot and dead-gap invariants throughout.
5. ch_mask changed from 6'b000011 to 6'b110000 during ch0's DWELL -> next channel is ch4, not ch1. Then change the mask to 0 during ch4's DWELL -> IDLE after ch4's dwell ends.
6. start with ch_mask=0 -> stays IDLE. start while busy -> no effect on the sequence. start and stop in the same cycle -> stays IDLE.
